// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter issuing HOLD/CLR/SET/TOG commands to a JK flip-flop bank and checking the result.
// Latency: handshake -> APPLY -> CHECK -> done pulse (3 cycles); ready is low while a command is in flight.
module jk_bank_arbiter #(
  parameter int N_BITS = 4,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [1:0]        req0_op,
  input  logic [IDX_W-1:0]  req0_idx,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [1:0]        req1_op,
  input  logic [IDX_W-1:0]  req1_idx,
  output logic              req1_ready,
  output logic [N_BITS-1:0] jk_J,
  output logic [N_BITS-1:0] jk_K,
  input  logic [N_BITS-1:0] jk_Q,
  output logic              busy,
  output logic              done_valid,
  output logic              done_src,
  output logic              done_q,
  output logic              done_err,
  output logic [7:0]        err_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_APPLY = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TOG  = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             src_q, src_d;
  logic             prev_bit_q, prev_bit_d;
  logic             last_q, last_d;
  logic             done_valid_q, done_valid_d;
  logic             done_src_q, done_src_d;
  logic             done_q_q, done_q_d;
  logic             done_err_q, done_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic             grant_vld;
  logic             grant_src;
  logic [1:0]       sel_op;
  logic [IDX_W-1:0] sel_idx;
  logic             cur_bit;
  logic             exp_bit;

  // On contention the requester not served last wins; last_q resets to 1 so req0 wins first.
  always_comb begin
    grant_vld = 1'b0;
    grant_src = 1'b0;
    if (state_q == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_vld = 1'b1;
        grant_src = ~last_q;
      end else if (req0_valid) begin
        grant_vld = 1'b1;
        grant_src = 1'b0;
      end else if (req1_valid) begin
        grant_vld = 1'b1;
        grant_src = 1'b1;
      end
    end
    sel_op  = grant_src ? req1_op  : req0_op;
    sel_idx = grant_src ? req1_idx : req0_idx;
  end

  assign req0_ready = grant_vld & ~grant_src;
  assign req1_ready = grant_vld &  grant_src;
  assign busy       = (state_q == ST_APPLY) || (state_q == ST_CHECK);

  always_comb begin
    cur_bit = jk_Q[idx_q];
    case (op_q)
      OP_HOLD: exp_bit = prev_bit_q;
      OP_CLR:  exp_bit = 1'b0;
      OP_SET:  exp_bit = 1'b1;
      default: exp_bit = ~prev_bit_q;
    endcase
  end

  always_comb begin
    jk_J = '0;
    jk_K = '0;
    if (state_q == ST_APPLY) begin
      jk_J[idx_q] = (op_q == OP_SET) || (op_q == OP_TOG);
      jk_K[idx_q] = (op_q == OP_CLR) || (op_q == OP_TOG);
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    idx_d        = idx_q;
    src_d        = src_q;
    prev_bit_d   = prev_bit_q;
    last_d       = last_q;
    done_valid_d = 1'b0;
    done_src_d   = done_src_q;
    done_q_d     = done_q_q;
    done_err_d   = done_err_q;
    err_cnt_d    = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          state_d    = ST_APPLY;
          op_d       = sel_op;
          idx_d      = sel_idx;
          src_d      = grant_src;
          prev_bit_d = jk_Q[sel_idx];
          last_d     = grant_src;
        end
      end
      ST_APPLY: state_d = ST_CHECK;
      ST_CHECK: begin
        state_d      = ST_IDLE;
        done_valid_d = 1'b1;
        done_src_d   = src_q;
        done_q_d     = cur_bit;
        done_err_d   = (cur_bit != exp_bit);
        if ((cur_bit != exp_bit) && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_HOLD;
      idx_q        <= '0;
      src_q        <= 1'b0;
      prev_bit_q   <= 1'b0;
      last_q       <= 1'b1;
      done_valid_q <= 1'b0;
      done_src_q   <= 1'b0;
      done_q_q     <= 1'b0;
      done_err_q   <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      idx_q        <= idx_d;
      src_q        <= src_d;
      prev_bit_q   <= prev_bit_d;
      last_q       <= last_d;
      done_valid_q <= done_valid_d;
      done_src_q   <= done_src_d;
      done_q_q     <= done_q_d;
      done_err_q   <= done_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign done_valid = done_valid_q;
  assign done_src   = done_src_q;
  assign done_q     = done_q_q;
  assign done_err   = done_err_q;
  assign err_cnt    = err_cnt_q;

endmodule
